// File: rtl/camera_capture_pkg.sv
// Shared definitions for the parallel camera capture path: FSM encoding,
// default frame geometry and the RGB565 field layout of an assembled pixel.
package camera_capture_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,  // waiting for the first vsync pulse after reset
    ST_IDLE    = 2'd1,  // between frames, waiting for the vsync falling edge
    ST_CAPTURE = 2'd2   // inside a captured frame
  } cap_state_t;

  localparam int H_PIXELS_DEF    = 160;
  localparam int V_LINES_DEF     = 120;
  localparam int BYTES_PER_PIXEL = 2;

  // RGB565 field positions inside pix_data, for frame-buffer consumers.
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_R_W   = 5;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_G_W   = 6;
  localparam int RGB565_B_LSB = 0;
  localparam int RGB565_B_W   = 5;

  typedef struct packed {
    logic [RGB565_R_W-1:0] r;
    logic [RGB565_G_W-1:0] g;
    logic [RGB565_B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/cam_edge_detect.sv
// Registered rise/fall detector for a single camera strobe (vsync, href).
// The previous level is held in a flop; edge outputs compare it with the
// current input, so an edge is reported in the cycle it first appears.
module cam_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Remember last cycle's level of the strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/camera_capture.sv
// Camera-side capture: pairs href bytes into RGB565 pixels and emits a
// linear frame-buffer write stream, with frame-done and sticky error flags.
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_we,
  output logic              frame_done,
  output logic [7:0]        line_cnt,
  output logic              err_short,
  output logic              err_overflow
);

  localparam int COL_W = $clog2(H_PIXELS + 1);

  localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(H_PIXELS);
  localparam logic [7:0]        LINE_MAX   = 8'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_PITCH = ADDR_W'(H_PIXELS);

  cap_state_t        state_q;
  logic              phase_q;
  logic [7:0]        hold_q;
  logic [COL_W-1:0]  col_q;
  logic [7:0]        line_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] line_base_q;
  logic [15:0]       pix_data_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic              pix_we_q;
  logic              frame_done_q;
  logic              err_short_q;
  logic              err_overflow_q;

  logic href_eff;
  logic vsync_rise, vsync_fall;
  logic href_rise, href_fall;
  logic cur_phase;
  logic line_full;

  // Line data is only meaningful outside vertical blanking.
  assign href_eff = href & ~vsync;

  cam_edge_detect u_vsync_edge (
    .clk_i  (pclk),
    .rst_i  (rst),
    .sig_i  (vsync),
    .rise_o (vsync_rise),
    .fall_o (vsync_fall)
  );

  cam_edge_detect u_href_edge (
    .clk_i  (pclk),
    .rst_i  (rst),
    .sig_i  (href_eff),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  // A new line always opens on a first byte, whatever phase was left over.
  assign cur_phase = href_rise ? 1'b0 : phase_q;

  // Completed pixels past the line or frame bounds are discarded.
  assign line_full = (col_q == COL_MAX) || (line_cnt_q == LINE_MAX);

  // Frame FSM, byte pairing, address generation and flags in one clocked block.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= ST_SYNC;
      phase_q        <= 1'b0;
      hold_q         <= '0;
      col_q          <= '0;
      line_cnt_q     <= '0;
      addr_q         <= '0;
      line_base_q    <= '0;
      pix_data_q     <= '0;
      pix_addr_q     <= '0;
      pix_we_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      err_short_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      // NOTE: strobes default low here so every path below yields a one-cycle
      // pulse; non-blocking assignments keep all state reads at pre-edge values.
      pix_we_q     <= 1'b0;
      frame_done_q <= 1'b0;

      unique case (state_q)
        ST_SYNC: begin
          if (vsync) state_q <= ST_IDLE;
        end

        ST_IDLE: begin
          if (vsync_fall) begin
            phase_q     <= 1'b0;
            col_q       <= '0;
            line_cnt_q  <= '0;
            addr_q      <= '0;
            line_base_q <= '0;
            if (capture_en) state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (vsync_rise) begin
            // End of frame wins over a coincident line end.
            frame_done_q <= 1'b1;
            phase_q      <= 1'b0;
            state_q      <= ST_IDLE;
            if (line_cnt_q != LINE_MAX) err_short_q <= 1'b1;
          end else if (href_fall) begin
            col_q <= '0;
            if (line_cnt_q != LINE_MAX) begin
              line_cnt_q  <= line_cnt_q + 8'd1;
              line_base_q <= line_base_q + LINE_PITCH;
              addr_q      <= line_base_q + LINE_PITCH;
            end
            if (phase_q) begin
              err_short_q <= 1'b1;
              phase_q     <= 1'b0;
            end
          end else if (href_eff) begin
            if (!cur_phase) begin
              hold_q  <= data;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (line_full) begin
                err_overflow_q <= 1'b1;
              end else begin
                pix_data_q <= {hold_q, data};
                pix_addr_q <= addr_q;
                pix_we_q   <= 1'b1;
                addr_q     <= addr_q + ADDR_W'(1);
                col_q      <= col_q + COL_W'(1);
              end
            end
          end
        end

        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign pix_data     = pix_data_q;
  assign pix_addr     = pix_addr_q;
  assign pix_we       = pix_we_q;
  assign frame_done   = frame_done_q;
  assign line_cnt     = line_cnt_q;
  assign err_short    = err_short_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: a camera driver with a small pixel model pushes
// expected frame-buffer writes into a queue; a monitor pops and compares them.
module tb_camera_capture;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int AW = 15;

  logic          pclk = 1'b0;
  logic          rst;
  logic          capture_en;
  logic          vsync;
  logic          href;
  logic [7:0]    data;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          pix_we;
  logic          frame_done;
  logic [7:0]    line_cnt;
  logic          err_short;
  logic          err_overflow;

  camera_capture #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .capture_en   (capture_en),
    .vsync        (vsync),
    .href         (href),
    .data         (data),
    .pix_data     (pix_data),
    .pix_addr     (pix_addr),
    .pix_we       (pix_we),
    .frame_done   (frame_done),
    .line_cnt     (line_cnt),
    .err_short    (err_short),
    .err_overflow (err_overflow)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp    = 0;
  int  n_bad    = 0;
  int  n_writes = 0;
  bit  capturing = 1'b0;
  int  exp_col  = 0;
  int  exp_line = 0;

  // Pops one expected write per observed pix_we, sampled on the falling edge.
  task automatic monitor_loop();
    wr_t e;
    forever begin
      @(negedge pclk);
      if (pix_we === 1'b1) begin
        n_writes++;
        n_cmp++;
        if (int'(pix_addr) >= H * V) begin
          n_bad++;
          $display("FAIL addr_range: got pix_addr=%0d, need < %0d", pix_addr, H * V);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", pix_addr, pix_data);
        end else begin
          e = exp_q.pop_front();
          if (pix_addr !== e.addr || pix_data !== e.data) begin
            n_bad++;
            $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     pix_addr, pix_data, e.addr, e.data);
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] pick(input int mode, input int i);
    if (mode == 0) return (i % 2 == 0) ? 8'hAA : 8'h55;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic push_exp(input logic [7:0] first, input logic [7:0] second);
    wr_t w;
    if (capturing && exp_col < H && exp_line < V) begin
      w.addr = AW'(exp_line * H + exp_col);
      w.data = {first, second};
      exp_q.push_back(w);
      exp_col++;
    end
  endtask

  // One href burst of nbytes followed by a single blanking cycle.
  task automatic send_line(input int nbytes, input int mode);
    logic [7:0] prev = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge pclk);
      b = pick(mode, i);
      href = 1'b1;
      data = b;
      if (i % 2 == 1) push_exp(prev, b);
      prev = b;
    end
    @(negedge pclk);
    href = 1'b0;
    data = 8'h00;
    if (capturing) begin
      if (exp_line < V) exp_line++;
      exp_col = 0;
    end
  endtask

  task automatic start_frame(input bit en);
    @(negedge pclk);
    href       = 1'b0;
    vsync      = 1'b1;
    capture_en = en;
    repeat (3) @(negedge pclk);
    vsync     = 1'b0;
    capturing = en;
    exp_col   = 0;
    exp_line  = 0;
    n_writes  = 0;
    @(negedge pclk);
  endtask

  task automatic end_frame(input bit exp_done);
    @(negedge pclk);
    vsync = 1'b1;
    @(negedge pclk);
    n_cmp++;
    if (frame_done !== exp_done) begin
      n_bad++;
      $display("FAIL frame_done: got %b, expected %b", frame_done, exp_done);
    end
    @(negedge pclk);
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_done_width: got %b one cycle later, expected 0", frame_done);
    end
    capturing = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: got %0d expected writes still pending, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00; capture_en = 1'b1;
    repeat (3) @(negedge pclk);
    n_cmp++;
    if ({pix_data, pix_addr, pix_we, frame_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h addr=%0d we=%b fd=%b, expected all 0",
               pix_data, pix_addr, pix_we, frame_done);
    end
    n_cmp++;
    if ({line_cnt, err_short, err_overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_status: got line_cnt=%0d es=%b eo=%b, expected 0",
               line_cnt, err_short, err_overflow);
    end
    rst = 1'b0;
    // Tail of a frame already in progress: must never reach the frame buffer.
    for (int l = 0; l < 3; l++) send_line(40, 1);
    @(negedge pclk);
    n_cmp++;
    if (n_writes != 0 || line_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL partial_frame: got writes=%0d line_cnt=%0d, expected 0/0", n_writes, line_cnt);
    end
  endtask

  task automatic test_full_frame();
    start_frame(1'b1);
    for (int l = 0; l < V; l++) send_line(2 * H, 0);
    @(negedge pclk);
    n_cmp++;
    if (line_cnt !== 8'(V)) begin
      n_bad++;
      $display("FAIL full_line_cnt: got %0d, expected %0d", line_cnt, V);
    end
    end_frame(1'b1);
    n_cmp++;
    if (n_writes != H * V) begin
      n_bad++;
      $display("FAIL full_write_count: got %0d, expected %0d", n_writes, H * V);
    end
    n_cmp++;
    if (err_short !== 1'b0 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL full_errors: got es=%b eo=%b, expected 0/0", err_short, err_overflow);
    end
  endtask

  task automatic test_back_to_back();
    start_frame(1'b1);
    for (int l = 0; l < V; l++) send_line(16, 1);
    end_frame(1'b1);
    n_cmp++;
    if (n_writes != V * 8) begin
      n_bad++;
      $display("FAIL b2b_write_count: got %0d, expected %0d", n_writes, V * 8);
    end
    n_cmp++;
    if (err_short !== 1'b0 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_errors: got es=%b eo=%b, expected 0/0", err_short, err_overflow);
    end
  endtask

  task automatic test_line_faults();
    start_frame(1'b1);
    for (int l = 0; l < 3; l++) send_line(8, 1);
    // Line 3 opens with 0x12, 0x34.
    @(negedge pclk);
    href = 1'b1; data = 8'h12;
    @(negedge pclk);
    data = 8'h34;
    push_exp(8'h12, 8'h34);
    n_cmp++;
    if (pix_we !== 1'b0) begin
      n_bad++;
      $display("FAIL early_write: got pix_we=%b after first byte, expected 0", pix_we);
    end
    @(negedge pclk);
    href = 1'b0; data = 8'h00;
    exp_line++; exp_col = 0;
    n_cmp++;
    if (pix_we !== 1'b1 || pix_data !== 16'h1234 || pix_addr !== AW'(480)) begin
      n_bad++;
      $display("FAIL first_pixel: got we=%b data=%h addr=%0d, expected 1/1234/480",
               pix_we, pix_data, pix_addr);
    end
    // Line 4: odd byte count.
    send_line(2 * H + 1, 1);
    @(negedge pclk);
    n_cmp++;
    if (err_short !== 1'b1 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL odd_line: got es=%b eo=%b, expected 1/0", err_short, err_overflow);
    end
    // Line 5 must start again at column 0.
    send_line(8, 1);
    // Line 6: too many bytes.
    send_line(2 * H + 10, 1);
    @(negedge pclk);
    n_cmp++;
    if (err_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL long_line: got eo=%b, expected 1", err_overflow);
    end
    for (int l = 7; l < V; l++) send_line(4, 1);
    end_frame(1'b1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] prev = 8'h00;
    logic [7:0] b;
    start_frame(1'b1);
    send_line(8, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      b = pick(1, i);
      href = 1'b1; data = b;
      if (i % 2 == 1) push_exp(prev, b);
      prev = b;
    end
    @(negedge pclk);
    rst = 1'b1; data = 8'h77;
    capturing = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
    n_cmp++;
    if (pix_we !== 1'b0 || pix_addr !== '0 || line_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_reset_out: got we=%b addr=%0d line_cnt=%0d, expected 0/0/0",
               pix_we, pix_addr, line_cnt);
    end
    n_cmp++;
    if (err_short !== 1'b0 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_err: got es=%b eo=%b, expected 0/0", err_short, err_overflow);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL mid_reset_pending: got %0d writes pending, expected 0", exp_q.size());
    end
    // Remainder of the interrupted frame stays out of the frame buffer.
    n_writes = 0;
    for (int l = 0; l < 3; l++) send_line(20, 1);
    n_cmp++;
    if (n_writes != 0) begin
      n_bad++;
      $display("FAIL mid_reset_writes: got %0d, expected 0", n_writes);
    end
  endtask

  task automatic test_frame_overflow();
    start_frame(1'b1);
    for (int l = 0; l < V; l++) send_line(4, 1);
    @(negedge pclk);
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_ovf_early: got eo=%b after %0d lines, expected 0", err_overflow, V);
    end
    for (int l = 0; l < 5; l++) send_line(4, 1);
    @(negedge pclk);
    n_cmp++;
    if (err_overflow !== 1'b1 || line_cnt !== 8'(V)) begin
      n_bad++;
      $display("FAIL frame_ovf: got eo=%b line_cnt=%0d, expected 1/%0d", err_overflow, line_cnt, V);
    end
    end_frame(1'b1);
    n_cmp++;
    if (err_short !== 1'b0 || n_writes != V * 2) begin
      n_bad++;
      $display("FAIL frame_ovf_tail: got es=%b writes=%0d, expected 0/%0d", err_short, n_writes, V * 2);
    end
  endtask

  task automatic test_capture_disable();
    start_frame(1'b0);
    for (int l = 0; l < 5; l++) send_line(8, 1);
    end_frame(1'b0);
    n_cmp++;
    if (n_writes != 0) begin
      n_bad++;
      $display("FAIL disabled_frame: got %0d writes, expected 0", n_writes);
    end
    start_frame(1'b1);
    for (int l = 0; l < V; l++) send_line(4, 1);
    end_frame(1'b1);
    n_cmp++;
    if (n_writes != V * 2) begin
      n_bad++;
      $display("FAIL reenabled_frame: got %0d writes, expected %0d", n_writes, V * 2);
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00; capture_en = 1'b0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_line_faults();
    test_mid_reset();
    test_frame_overflow();
    test_capture_disable();
    repeat (4) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
